demux1x2_n_reg: RTL and testbench

- Registered 1-to-2 demultiplexer for BITS-wide words, with valid/ready handshakes on the input and on each output.
- Routes each accepted input word to destination 0 or 1 according to SEL.
- Each destination has a one-entry holding register, so a stalled destination never corrupts or loses data.
- Serves as the distribution end of datapaths whose merge end is the mux2x1_n combinational selector.

---
 rtl/demux1x2_n_reg.sv | 134 +++++++++++++
 tb/tb_demux1x2_n_reg.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_n_reg.sv
// demux1x2_n_reg: registered 1-to-2 demultiplexer with valid/ready handshakes.
// Each accepted word goes to OUT0 or OUT1 according to SEL and sits in a
// one-entry holding register until that destination takes it.
// Optional feature macro: DEMUX_CONTAGEM_EN adds per-destination
// delivered-word counters (contagem0/contagem1, CNT_BITS wide, wrapping).
module demux1x2_n_reg #(
    parameter int BITS     = 4,
    parameter int CNT_BITS = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [BITS-1:0] D,
    input  logic            SEL,
    input  logic            entrada_valida,
    output logic            entrada_pronta,
    output logic [BITS-1:0] OUT0,
    output logic            valido0,
    input  logic            pronto0,
    output logic [BITS-1:0] OUT1,
    output logic            valido1,
    input  logic            pronto1
`ifdef DEMUX_CONTAGEM_EN
    ,
    output logic [CNT_BITS-1:0] contagem0,
    output logic [CNT_BITS-1:0] contagem1
`endif
);

    // Per-destination holding register state.
    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

    logic [1:0] pronto_vec;
    logic [1:0] valido_vec;
    logic [1:0] load_vec;

    assign pronto_vec = {pronto1, pronto0};

    // A destination can take a new word when it is empty or is being drained
    // this very cycle; only the selected destination matters.
    assign entrada_pronta = SEL ? (~valido1 | pronto1) : (~valido0 | pronto0);

    // Decode the input transfer into a per-destination load strobe. An unknown
    // SEL matches neither branch, so no register is loaded.
    always_comb begin
        load_vec = 2'b00;
        if (entrada_valida && entrada_pronta) begin
            if (SEL == 1'b0) begin
                load_vec[0] = 1'b1;
            end else if (SEL == 1'b1) begin
                load_vec[1] = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_saida
            estado_t         state_reg;
            estado_t         state_next;
            logic [BITS-1:0] data_reg;
            logic [BITS-1:0] data_next;
            logic            entrega;

            // Word leaves the holding register when the destination is ready.
            assign entrega = (state_reg == CHEIO) && pronto_vec[gi];

            // Next-state logic: a load always wins (and replaces a word being
            // delivered in the same cycle), otherwise a delivery empties the slot.
            always_comb begin
                state_next = state_reg;
                data_next  = data_reg;
                case (state_reg)
                    VAZIO: begin
                        if (load_vec[gi]) begin
                            state_next = CHEIO;
                            data_next  = D;
                        end
                    end
                    CHEIO: begin
                        if (load_vec[gi]) begin
                            state_next = CHEIO;
                            data_next  = D;
                        end else if (entrega) begin
                            state_next = VAZIO;
                        end
                    end
                    default: begin
                        state_next = VAZIO;
                    end
                endcase
            end

            // State and data registers; reset discards any pending word.
            always_ff @(posedge clock) begin
                if (reset) begin
                    state_reg <= VAZIO;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    data_reg  <= data_next;
                end
            end

            assign valido_vec[gi] = (state_reg == CHEIO);

`ifdef DEMUX_CONTAGEM_EN
            logic [CNT_BITS-1:0] cnt_reg;

            // Delivered-word counter; reset has priority so a delivery in the
            // reset cycle is not counted. Wraps naturally.
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (entrega) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
`endif
        end
    endgenerate

    assign OUT0    = g_saida[0].data_reg;
    assign OUT1    = g_saida[1].data_reg;
    assign valido0 = valido_vec[0];
    assign valido1 = valido_vec[1];

`ifdef DEMUX_CONTAGEM_EN
    assign contagem0 = g_saida[0].cnt_reg;
    assign contagem1 = g_saida[1].cnt_reg;
`endif

endmodule

// File: tb/tb_demux1x2_n_reg.sv
// Directed testbench for demux1x2_n_reg. Counter checks (and a second
// instance with CNT_BITS=2 for the wrap test) exist only with DEMUX_CONTAGEM_EN.
module tb_demux1x2_n_reg;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] D = 4'b0000;
    logic       SEL = 1'b0;
    logic       entrada_valida = 1'b0;
    logic       pronto0 = 1'b0;
    logic       pronto1 = 1'b0;
    logic       entrada_pronta;
    logic [3:0] OUT0;
    logic [3:0] OUT1;
    logic       valido0;
    logic       valido1;

    int tests = 0;
    int fails = 0;

`ifdef DEMUX_CONTAGEM_EN
    logic [7:0] contagem0;
    logic [7:0] contagem1;
    logic       w_entrada_pronta;
    logic [3:0] w_out0;
    logic [3:0] w_out1;
    logic       w_valido0;
    logic       w_valido1;
    logic [1:0] w_contagem0;
    logic [1:0] w_contagem1;
`endif

    always #5 clock = ~clock;

    demux1x2_n_reg #(.BITS(4), .CNT_BITS(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .D              (D),
        .SEL            (SEL),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .OUT0           (OUT0),
        .valido0        (valido0),
        .pronto0        (pronto0),
        .OUT1           (OUT1),
        .valido1        (valido1),
        .pronto1        (pronto1)
`ifdef DEMUX_CONTAGEM_EN
        ,
        .contagem0      (contagem0),
        .contagem1      (contagem1)
`endif
    );

`ifdef DEMUX_CONTAGEM_EN
    demux1x2_n_reg #(.BITS(4), .CNT_BITS(2)) dut_wrap (
        .clock          (clock),
        .reset          (reset),
        .D              (D),
        .SEL            (SEL),
        .entrada_valida (entrada_valida),
        .entrada_pronta (w_entrada_pronta),
        .OUT0           (w_out0),
        .valido0        (w_valido0),
        .pronto0        (pronto0),
        .OUT1           (w_out1),
        .valido1        (w_valido1),
        .pronto1        (pronto1),
        .contagem0      (w_contagem0),
        .contagem1      (w_contagem1)
    );
`endif

    task automatic apply_reset();
        reset = 1'b1;
        entrada_valida = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        SEL = 1'b0;
        apply_reset();
        #1;
        tests++; if (OUT0 !== 4'b0000) begin fails++; $display("FAIL reset_out0: got %b expected 0000", OUT0); end
        tests++; if (OUT1 !== 4'b0000) begin fails++; $display("FAIL reset_out1: got %b expected 0000", OUT1); end
        tests++; if (valido0 !== 1'b0) begin fails++; $display("FAIL reset_valido0: got %b expected 0", valido0); end
        tests++; if (valido1 !== 1'b0) begin fails++; $display("FAIL reset_valido1: got %b expected 0", valido1); end
        tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL reset_pronta: got %b expected 1", entrada_pronta); end
`ifdef DEMUX_CONTAGEM_EN
        tests++; if (contagem0 !== 8'd0 || contagem1 !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", contagem0, contagem1); end
`endif
        $display("[TB] reset done");
    endtask

    task automatic test_single_word();
        apply_reset();
        D = 4'b1010; SEL = 1'b0; entrada_valida = 1'b1; pronto0 = 1'b1; pronto1 = 1'b1;
        #1;
        tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL single_pronta: got %b expected 1", entrada_pronta); end
        @(posedge clock); #1;
        entrada_valida = 1'b0;
        tests++; if (OUT0 !== 4'b1010) begin fails++; $display("FAIL single_out0: got %b expected 1010", OUT0); end
        tests++; if (valido0 !== 1'b1) begin fails++; $display("FAIL single_valido0: got %b expected 1", valido0); end
        tests++; if (valido1 !== 1'b0) begin fails++; $display("FAIL single_valido1: got %b expected 0", valido1); end
        @(posedge clock); #1;
        tests++; if (valido0 !== 1'b0) begin fails++; $display("FAIL single_drained: got %b expected 0", valido0); end
        tests++; if (valido1 !== 1'b0 || OUT1 !== 4'b0000) begin fails++; $display("FAIL single_out1_untouched: got %b/%b expected 0/0000", valido1, OUT1); end
        $display("[TB] word 1010 -> out0");
    endtask

    task automatic test_stall();
        apply_reset();
        pronto0 = 1'b1; pronto1 = 1'b0;
        D = 4'b0101; SEL = 1'b1; entrada_valida = 1'b1;
        @(posedge clock); #1;
        D = 4'b0011; SEL = 1'b1;
        #1;
        tests++; if (entrada_pronta !== 1'b0) begin fails++; $display("FAIL stall_refuse: got %b expected 0", entrada_pronta); end
        @(posedge clock); #1;
        tests++; if (OUT1 !== 4'b0101) begin fails++; $display("FAIL stall_hold_out1: got %b expected 0101", OUT1); end
        tests++; if (valido1 !== 1'b1) begin fails++; $display("FAIL stall_hold_valido1: got %b expected 1", valido1); end
        SEL = 1'b0;
        #1;
        tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL stall_other_open: got %b expected 1", entrada_pronta); end
        SEL = 1'b1; pronto1 = 1'b1;
        #1;
        tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL stall_release: got %b expected 1", entrada_pronta); end
        @(posedge clock); #1;
        entrada_valida = 1'b0;
        tests++; if (OUT1 !== 4'b0011) begin fails++; $display("FAIL stall_next_out1: got %b expected 0011", OUT1); end
        tests++; if (valido1 !== 1'b1) begin fails++; $display("FAIL stall_next_valido1: got %b expected 1", valido1); end
        tests++; if (valido0 !== 1'b0) begin fails++; $display("FAIL stall_valido0: got %b expected 0", valido0); end
        @(posedge clock); #1;
        tests++; if (valido1 !== 1'b0) begin fails++; $display("FAIL stall_drained: got %b expected 0", valido1); end
`ifdef DEMUX_CONTAGEM_EN
        tests++; if (contagem1 !== 8'd2 || contagem0 !== 8'd0) begin fails++; $display("FAIL stall_cnt: got %0d/%0d expected 0/2", contagem0, contagem1); end
`endif
        $display("[TB] words 0101,0011 -> out1 with stall");
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        apply_reset();
        pronto0 = 1'b1; pronto1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            w = 4'(i);
            D = w; SEL = ((i % 2) == 0); entrada_valida = 1'b1;
            #1;
            tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL stream_pronta[%0d]: got %b expected 1", i, entrada_pronta); end
            @(posedge clock); #1;
            if ((i % 2) == 1) begin
                tests++; if (OUT0 !== w || valido0 !== 1'b1) begin fails++; $display("FAIL stream_out0[%0d]: got %b/%b expected %b/1", i, OUT0, valido0, w); end
                if (i > 1) begin
                    tests++; if (valido1 !== 1'b0) begin fails++; $display("FAIL stream_valido1[%0d]: got %b expected 0", i, valido1); end
                end
            end else begin
                tests++; if (OUT1 !== w || valido1 !== 1'b1) begin fails++; $display("FAIL stream_out1[%0d]: got %b/%b expected %b/1", i, OUT1, valido1, w); end
                tests++; if (valido0 !== 1'b0) begin fails++; $display("FAIL stream_valido0[%0d]: got %b expected 0", i, valido0); end
            end
            $display("[TB] word %b -> out%0d", w, (i % 2) == 0);
        end
        entrada_valida = 1'b0;
        @(posedge clock); #1;
        tests++; if (valido0 !== 1'b0 || valido1 !== 1'b0) begin fails++; $display("FAIL stream_drained: got %b/%b expected 0/0", valido0, valido1); end
`ifdef DEMUX_CONTAGEM_EN
        tests++; if (contagem0 !== 8'd4 || contagem1 !== 8'd4) begin fails++; $display("FAIL stream_cnt: got %0d/%0d expected 4/4", contagem0, contagem1); end
`endif
    endtask

    task automatic test_both_full();
        apply_reset();
        pronto0 = 1'b0; pronto1 = 1'b0;
        D = 4'b0110; SEL = 1'b0; entrada_valida = 1'b1;
        @(posedge clock); #1;
        D = 4'b1001; SEL = 1'b1;
        @(posedge clock); #1;
        SEL = 1'b0;
        #1;
        tests++; if (entrada_pronta !== 1'b0) begin fails++; $display("FAIL full_pronta_sel0: got %b expected 0", entrada_pronta); end
        SEL = 1'b1;
        #1;
        tests++; if (entrada_pronta !== 1'b0) begin fails++; $display("FAIL full_pronta_sel1: got %b expected 0", entrada_pronta); end
        D = 4'b1100;
        @(posedge clock); #1;
        entrada_valida = 1'b0;
        tests++; if (OUT0 !== 4'b0110 || OUT1 !== 4'b1001) begin fails++; $display("FAIL full_hold: got %b/%b expected 0110/1001", OUT0, OUT1); end
        tests++; if (valido0 !== 1'b1 || valido1 !== 1'b1) begin fails++; $display("FAIL full_valid: got %b/%b expected 1/1", valido0, valido1); end
        $display("[TB] both outputs full, input blocked");
    endtask

    task automatic test_reset_pending();
        apply_reset();
        pronto0 = 1'b0; pronto1 = 1'b0;
        D = 4'b1111; SEL = 1'b0; entrada_valida = 1'b1;
        @(posedge clock); #1;
        entrada_valida = 1'b0;
        tests++; if (OUT0 !== 4'b1111 || valido0 !== 1'b1) begin fails++; $display("FAIL pend_loaded: got %b/%b expected 1111/1", OUT0, valido0); end
        reset = 1'b1; pronto0 = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        tests++; if (valido0 !== 1'b0) begin fails++; $display("FAIL pend_valido0: got %b expected 0", valido0); end
        tests++; if (OUT0 !== 4'b0000) begin fails++; $display("FAIL pend_out0: got %b expected 0000", OUT0); end
        @(posedge clock); #1;
        tests++; if (valido0 !== 1'b0) begin fails++; $display("FAIL pend_stays_empty: got %b expected 0", valido0); end
`ifdef DEMUX_CONTAGEM_EN
        tests++; if (contagem0 !== 8'd0) begin fails++; $display("FAIL pend_cnt0: got %0d expected 0", contagem0); end
`endif
        $display("[TB] pending word discarded by reset");
    endtask

`ifdef DEMUX_CONTAGEM_EN
    task automatic test_counter_wrap();
        logic [1:0] exp_w [5];
        exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        pronto0 = 1'b1; pronto1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            D = 4'(i + 3); SEL = 1'b1; entrada_valida = 1'b1;
            @(posedge clock); #1;
            entrada_valida = 1'b0;
            @(posedge clock); #1;
            tests++; if (w_contagem1 !== exp_w[i]) begin fails++; $display("FAIL wrap_cnt1[%0d]: got %0d expected %0d", i, w_contagem1, exp_w[i]); end
            tests++; if (contagem1 !== 8'(i + 1)) begin fails++; $display("FAIL wide_cnt1[%0d]: got %0d expected %0d", i, contagem1, i + 1); end
            $display("[TB] delivery %0d on out1, 2-bit count %0d", i + 1, w_contagem1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_back_to_back();
        test_both_full();
        test_reset_pending();
`ifdef DEMUX_CONTAGEM_EN
        test_counter_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
